// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS main control: opcodes, ALU operation classes
// and the control bundle carried down the pipeline.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        AluAdd    = 2'b00,
        AluBranch = 2'b01,
        AluRtype  = 2'b10,
        AluImm    = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu_op;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    memto_reg;
        logic    link;
        logic    jump;
        logic    branch;
        logic    br_ne;     // branch sense: 1 = bne, 0 = beq
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage opcode decode into a control bundle, plus the
// rt-usage and illegal-opcode indications.
module ctrl_decode
    import mips_pkg::*;
#(
    parameter int unsigned EXT_OPS = 0
) (
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       uses_rt_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = '0;
        uses_rt_o = 1'b0;
        illegal_o = 1'b0;
        unique case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.memto_reg = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = AluRtype;
                uses_rt_o        = 1'b1;
            end
            OP_ADDI, OP_ANDI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.memto_reg = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                uses_rt_o        = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o.alu_op = AluBranch;
                ctrl_o.branch = 1'b1;
                ctrl_o.br_ne  = (opcode_i == OP_BNE);
                uses_rt_o     = 1'b1;
            end
            OP_J: ctrl_o.jump = 1'b1;
            OP_ORI, OP_SLTI: begin
                if (EXT_OPS != 0) begin
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.memto_reg = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_op    = AluImm;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_JAL: begin
                if (EXT_OPS != 0) begin
                    ctrl_o.jump      = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.link      = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Main pipeline control: carries the decoded bundle through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards and drives PC redirect / flush controls.
module ctrl_pipe_unit
    import mips_pkg::*;
#(
    parameter int unsigned RA_W     = 5,
    parameter int unsigned BR_STAGE = 0,
    parameter int unsigned EXT_OPS  = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [5:0]       opcode_i,
    input  logic [RA_W-1:0]  id_rs_i,
    input  logic [RA_W-1:0]  id_rt_i,
    input  logic             br_eq_i,
    output logic             ex_reg_dst_o,
    output logic             ex_alu_src_o,
    output logic [1:0]       ex_alu_op_o,
    output logic [RA_W-1:0]  ex_rt_o,
    output logic             mem_mem_read_o,
    output logic             mem_mem_write_o,
    output logic             wb_reg_write_o,
    output logic             wb_memto_reg_o,
    output logic             wb_link_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             jump_sel_o,
    output logic             br_sel_o,
    output logic             if_flush_o,
    output logic             id_flush_o,
    output logic             illegal_op_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_t             id_ctrl, ex_d, ex_q, mem_q, wb_q;
    logic [RA_W-1:0]   ex_rt_d, ex_rt_q;
    logic              illegal_d, illegal_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              id_uses_rt, id_illegal;
    logic              hz, ex_taken, id_taken, stall;

    ctrl_decode #(
        .EXT_OPS(EXT_OPS)
    ) u_decode (
        .opcode_i (opcode_i),
        .ctrl_o   (id_ctrl),
        .uses_rt_o(id_uses_rt),
        .illegal_o(id_illegal)
    );

    always_comb begin
        hz = ex_q.mem_read && (ex_rt_q != '0) &&
             ((ex_rt_q == id_rs_i) || (id_uses_rt && (ex_rt_q == id_rt_i)));
        ex_taken = (BR_STAGE != 0) && ex_q.branch && (ex_q.br_ne ? !br_eq_i : br_eq_i);
        id_taken = (BR_STAGE == 0) && id_ctrl.branch && (id_ctrl.br_ne ? !br_eq_i : br_eq_i);
        // A taken EX branch squashes the consumer, so its hazard is moot.
        stall = hz && !ex_taken;
    end

    always_comb begin
        pc_write_o   = !stall;
        ifid_write_o = !stall;
        jump_sel_o   = 1'b0;
        br_sel_o     = 1'b0;
        if_flush_o   = 1'b0;
        id_flush_o   = 1'b0;
        // A stalled branch or jump waits in ID and is re-evaluated next cycle.
        if (rst_ni && !stall) begin
            if (ex_taken) begin
                br_sel_o   = 1'b1;
                if_flush_o = 1'b1;
                id_flush_o = 1'b1;
            end else begin
                br_sel_o   = id_taken;
                jump_sel_o = id_ctrl.jump;
                if_flush_o = id_taken || id_ctrl.jump;
            end
        end
    end

    always_comb begin
        ex_d      = id_ctrl;
        ex_rt_d   = id_rt_i;
        illegal_d = illegal_q || id_illegal;
        cnt_d     = cnt_q;
        if (stall || ex_taken) begin
            ex_d    = '0;
            ex_rt_d = '0;
        end
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_rt_q   <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= ex_q;
            wb_q      <= mem_q;
            ex_rt_q   <= ex_rt_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_reg_dst_o    = ex_q.reg_dst;
    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign ex_rt_o         = ex_rt_q;
    assign mem_mem_read_o  = mem_q.mem_read;
    assign mem_mem_write_o = mem_q.mem_write;
    assign wb_reg_write_o  = wb_q.reg_write;
    assign wb_memto_reg_o  = wb_q.memto_reg;
    assign wb_link_o       = wb_q.link;
    assign illegal_op_o    = illegal_q;
    assign stall_cnt_o     = cnt_q;

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Second-generation main control for the 5-stage MIPS core.
- Decodes the ID-stage opcode, carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers, and detects load-use hazards (stall plus bubble).
- Flushes only on jumps and resolved-taken branches; branches are no longer flushed unconditionally.
- Parametrised for the branch-resolve stage, an extended opcode set and the width of the stall performance counter.

Parameters:
- RA_W, 5: register-address width.
- BR_STAGE, 0: 0 = branch resolved in ID (1-cycle penalty); 1 = branch resolved in EX (2-cycle penalty).
- EXT_OPS, 0: 1 = also decode ori (001101), slti (001010) and jal (000011).
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- opcode  in  6  instr[31:26] of the instruction in ID.
- id_rs  in  RA_W  rs field of the instruction in ID.
- id_rt  in  RA_W  rt field of the instruction in ID.
- br_eq  in  1  rs==rt comparison for the branch at the resolve stage (ID if BR_STAGE=0, EX if BR_STAGE=1).
- ex_RegDst, ex_ALUSrc  out  1  EX-stage controls.
- ex_ALUOp  out  2  EX-stage ALU operation class.
- ex_rt  out  RA_W  registered rt of the instruction in EX.
- mem_MemRead, mem_MemWrite  out  1  MEM-stage controls.
- wb_RegWrite, wb_MemtoReg, wb_Link  out  1  WB-stage controls.
- pc_write, ifid_write  out  1  0 = hold PC / hold the IF/ID register.
- jump_sel  out  1  selects the jump target for the PC.
- br_sel  out  1  selects the branch target for the PC.
- IF_Flush, ID_Flush  out  1  clear IF/ID; ID/EX bubble.
- illegal_op  out  1  sticky flag: an undecoded opcode was seen in ID.
- stall_cnt  out  CNT_W  number of load-use stall cycles.

Behaviour:
- Decode (combinational, ID stage):
  - R-type 000000: RegDst=1, MemtoReg=1, RegWrite=1, ALUOp=10.
  - addi, andi: ALUSrc=1, MemtoReg=1, RegWrite=1, ALUOp=00.
  - lw: MemRead=1, ALUSrc=1, RegWrite=1, MemtoReg=0, ALUOp=00.
  - sw: MemWrite=1, ALUSrc=1, ALUOp=00.
  - beq/bne: ALUOp=01; no writes.
  - j: jump.
  - EXT_OPS=1 adds: ori and slti as I-type ALU ops with ALUOp=11; jal sets jump, RegWrite=1 and Link=1.
  - MemtoReg=1 selects the ALU result.
  - Any other opcode decodes to an all-zero bundle and sets illegal_op. illegal_op clears only on reset.
- Pipeline: the decoded bundle appears on ex_* one cycle after ID, on mem_* after two cycles and on wb_* after three. The bundle registers update every cycle; they are not stalled.
- Load-use hazard: hz = ex_MemRead & (ex_rt != 0) & (ex_rt == id_rs | (uses_rt & ex_rt == id_rt)). uses_rt is true for R-type, beq, bne and sw.
- On hz:
  - pc_write=0, ifid_write=0.
  - The ID/EX bundle loads zeros (bubble); ex_rt loads 0.
  - stall_cnt increments, saturating at all ones.
- Control flow with BR_STAGE=0:
  - taken = (beq & br_eq) | (bne & ~br_eq), evaluated in ID.
  - taken or jump: IF_Flush=1, br_sel/jump_sel=1.
  - Not taken: no flush.
  - hz has priority over a branch in ID. The branch waits, and br_eq is re-evaluated on the next cycle.
- Control flow with BR_STAGE=1:
  - The branch type (beq/bne) is registered into the ID/EX bundle. taken is evaluated in EX using br_eq.
  - taken: IF_Flush=1, ID_Flush=1 (the ID/EX bundle loads zeros), br_sel=1.
  - A jump in ID still flushes IF only.
  - A taken branch in EX overrides hz in the same cycle: no stall, the stall counter does not increment, and pc_write=1.
  - A taken EX branch plus a jump in ID: the branch wins and jump_sel=0.
- Reset (asynchronous, while reset=0): all registered bundles, ex_rt, illegal_op and stall_cnt are 0.
- Outputs during and after reset:
  - pc_write=1 and ifid_write=1 whenever hz=0.
  - Flush outputs are combinational from the current state; they are 0 while reset is asserted.
  - A reset asserted mid-stall or mid-flush drops the pending bubble.
- Combinational outputs: IF_Flush, ID_Flush, pc_write, ifid_write, br_sel and jump_sel are combinational. All ex_/mem_/wb_ outputs are registered.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J, OP_JAL).
  - ALUOp encodings.
  - a packed struct ctrl_t for the control bundle.
- One sub-module, ctrl_decode: the purely combinational opcode-to-ctrl_t decode plus the illegal indication.
- ctrl_pipe_unit contains the stage registers, hazard/flush logic and counters.

Test Plan:
1. lw $t0 (rt=8) in ID, then add with rs=8 -> exactly one cycle of pc_write=0 and ifid_write=0; the ex_ bundle is all zero for one cycle; stall_cnt 0->1; the add reaches wb_RegWrite=1 four cycles after it entered ID.
2. BR_STAGE=0: beq with br_eq=0 -> IF_Flush stays 0. bne with br_eq=0 -> IF_Flush=1 and br_sel=1 in the same cycle.
3. BR_STAGE=1: lw rt=9 in EX, taken beq in EX, and a consumer of rs=9 in ID in one cycle -> IF_Flush=1, ID_Flush=1, pc_write=1, stall_cnt unchanged.
4. Opcode 111111 in ID -> illegal_op=1 from the next edge and stays 1 through later legal opcodes; a zero bundle propagates. Driving reset=0 mid-cycle clears it immediately.
5. CNT_W=2 with 5 back-to-back load-use stalls -> stall_cnt reads 3 and holds at 3.
6. EXT_OPS=1: jal -> jump_sel=1, IF_Flush=1; wb_RegWrite=1 and wb_Link=1 three cycles later. With EXT_OPS=0 the same opcode sets illegal_op.
